uart_byte_tx: RTL and testbench
===============================

# uart_byte_tx

Byte-stream UART transmitter with a small input FIFO. It serialises bytes from an on-chip producer, such as the image/weight loader or the debug path, into 8-N-1 style frames on a single `txd` line. Its `txd` drives the `rs232_ex_RXD` input of the Qsys system, or the board RS-232 pin, so it is the transmitting end of that link. The frame format is set by parameters; the baud divisor is fixed at elaboration.

## Interface
Parameters:
- `CLK_FREQ`, 50000000: `clk_clk` frequency in Hz.
- `BAUD`, 115200: line rate. The divisor is `DIV = (CLK_FREQ + BAUD/2) / BAUD`, which is 434 at the defaults. `DIV` must be ≥ 2.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `FIFO_DEPTH`, 16: input FIFO depth. Must be a power of two, ≥ 2.

Ports:
- `clk_clk`, in, 1: sole clock.
- `reset_reset_n`, in, 1: reset, asynchronous assert, active-low.
- `tx_data`, in, 8: byte to send.
- `tx_valid`, in, 1: producer offers `tx_data`.
- `tx_ready`, out, 1: FIFO not full. A byte is accepted on any edge where `tx_valid && tx_ready`.
- `txd`, out, 1: serial line output, registered. Idle level is 1.
- `busy`, out, 1: a frame is on the line, or the FIFO is non-empty.
- `fifo_level`, out, $clog2(FIFO_DEPTH)+1: number of bytes queued, excluding the byte in flight.

## Operation
- **FIFO**
  - Circular buffer with write and read pointers one bit wider than the address, so full and empty are unambiguous.
  - `tx_ready = !full`, computed from registered state only. No combinational path from `tx_valid`.
  - Push while full is impossible by construction.
  - Push and pop on the same edge: both happen, and the level is unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: `txd`=1. If the FIFO is non-empty, pop into `shreg`, clear `bitcnt`, load `baudcnt`=DIV-1 and go to START.
  - START: `txd`=0.
  - DATA: `txd`=`shreg[0]`, sent LSB first. Shift right when each bit ends. After 8 bits go to PARITY if `PARITY`≠0, otherwise to STOP.
  - PARITY: `txd` = XOR of the 8 data bits for even parity, inverted for odd. The parity value is computed when the byte is popped.
  - STOP: `txd`=1 for `STOP_BITS`×DIV cycles.
  - A bit ends when `baudcnt` reaches 0. `baudcnt` then reloads DIV-1.
  - At the end of STOP:
    - FIFO non-empty: pop directly and go to START. There is no idle gap between frames.
    - FIFO empty: go to IDLE.
- **Timing of `txd`:** a registered copy of the state-derived level, so every bit lasts exactly DIV cycles.
- `busy` = (state≠IDLE) || !empty.
- **Reset** (async, at any point, including mid-frame):
  - `txd`=1, `tx_ready`=1, `busy`=0, `fifo_level`=0.
  - FSM returns to IDLE and FIFO pointers return to 0.
  - A partial frame is abandoned. The line simply returns high.
- Producer may hold `tx_valid` high continuously. The block throttles it only via `tx_ready`.

## Timing
- **Latency:** byte accepted at edge N into an empty FIFO with the FSM in IDLE:
  - pop occurs at edge N+1;
  - `txd` falls after edge N+2.
- **Frame length:** (1 + 8 + (PARITY≠0) + STOP_BITS) × DIV cycles.
- **Back-to-back frames:** the next start bit's falling edge follows the last stop cycle with no extra cycle.
- **`fifo_level`:** updates the cycle after a push or pop.

## Structure
- **Shared package `uart_pkg`:**
  - the state enum;
  - parity-mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - a divisor function `baud_div(clk, baud)`.
  - The matching receiver reuses this package.
- **Sub-module `sync_fifo`:** parameterised width and depth, with outputs `full`, `empty` and `level`. The FSM, baud counter and shifter stay in the top.
- Expected size: ~200 lines of RTL total.

## Test plan
Scenarios 1–4 use `CLK_FREQ`=1000 and `BAUD`=100, giving DIV=10.

1. **Single byte.** Reset, then push 0x55 once. Require:
   - `txd` low 2 cycles after the accepting edge;
   - then 1,0,1,0,1,0,1,0, each exactly 10 cycles;
   - stop bit high for 10 cycles;
   - `busy` falls and `txd` stays 1.
2. **Even parity.** `PARITY`=2, push 0x07. Require a parity bit of 1.
   - With `PARITY`=1, require 0.
   - Frame length is 110 cycles.
3. **Back-pressure.** Hold `tx_valid` high with bytes 0x00–0x1F and `FIFO_DEPTH`=16. Require:
   - `tx_ready` drops once 16 bytes are queued plus 1 in flight;
   - all 32 bytes appear on `txd` in order;
   - frames are contiguous, with no idle cycles between them.
4. **Simultaneous push and pop.** A push coincides with a FSM pop at a stop-bit end. Require `fifo_level` unchanged and no byte lost or duplicated.
5. **Mid-frame reset.** Assert `reset_reset_n` low during bit 3 of 0xA5. Require:
   - `txd`=1 immediately;
   - `fifo_level`=0;
   - after release, no residual frame.
   - A new push of 0x3C is then sent correctly.
6. **Default rate.** `CLK_FREQ`=50000000 and `BAUD`=115200. Require each bit to be 434 cycles, and a loopback into the Qsys system's `rs232_ex_RXD` to receive the byte 0xC3 intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity modes and the baud divisor helper.
// Used by both the transmitter and the matching receiver.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned ST_W = 3;
  typedef logic [ST_W-1:0] uart_state_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Rounded clock cycles per bit
  function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud);
    return (clk + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO, pointers one bit wider than the address so full/empty are distinct.
// Read data is shown from the head entry without a read strobe (first-word fall-through).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_wr_en && !o_full;
  assign w_pop  = i_rd_en && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-stream UART transmitter: input FIFO feeding a start/data/parity/stop serialiser.
// txd is a registered copy of the state-derived line level, so every bit lasts exactly DIV cycles.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned DIV         = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned CW          = $clog2(DIV);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(DIV - 1);
  localparam logic [2:0] STOP_LAST    = 3'(STOP_BITS - 1);
  localparam bit ODD_PAR              = (PARITY == PAR_ODD);
  localparam bit HAS_PAR              = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);

  logic [2:0]    r_state;
  logic [7:0]    r_shreg;
  logic [2:0]    r_bitcnt;
  logic [CW-1:0] r_baudcnt;
  logic          r_par;
  logic          r_txd;

  logic [2:0]    w_state_nxt;
  logic [7:0]    w_shreg_nxt;
  logic [2:0]    w_bitcnt_nxt;
  logic [CW-1:0] w_baudcnt_nxt;
  logic          w_par_nxt;
  logic          w_txd_lvl;
  logic          w_load;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_fifo_data;
  logic          w_full;
  logic          w_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .i_wr_en   (tx_valid),
    .i_wr_data (tx_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (fifo_level)
  );

  assign w_bit_end = (r_baudcnt == '0);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_baudcnt <= '0;
      r_par     <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_baudcnt <= w_baudcnt_nxt;
      r_par     <= w_par_nxt;
      r_txd     <= w_txd_lvl;
    end
  end

  // Next-state, bit timing and line level; bitcnt doubles as the stop-bit counter
  always_comb begin
    w_state_nxt   = r_state;
    w_shreg_nxt   = r_shreg;
    w_bitcnt_nxt  = r_bitcnt;
    w_baudcnt_nxt = r_baudcnt;
    w_par_nxt     = r_par;
    w_txd_lvl     = 1'b1;
    w_load        = 1'b0;
    w_pop         = 1'b0;

    if (r_state != ST_IDLE) begin
      w_baudcnt_nxt = w_bit_end ? BAUD_LOAD : r_baudcnt - CW'(1);
    end

    case (r_state)
      ST_IDLE: begin
        w_txd_lvl = 1'b1;
        if (!w_empty) w_load = 1'b1;
      end
      ST_START: begin
        w_txd_lvl = 1'b0;
        if (w_bit_end) begin
          w_state_nxt  = ST_DATA;
          w_bitcnt_nxt = '0;
        end
      end
      ST_DATA: begin
        w_txd_lvl = r_shreg[0];
        if (w_bit_end) begin
          w_shreg_nxt = {1'b0, r_shreg[7:1]};
          if (r_bitcnt == 3'd7) begin
            w_bitcnt_nxt = '0;
            w_state_nxt  = HAS_PAR ? ST_PARITY : ST_STOP;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        w_txd_lvl = r_par;
        if (w_bit_end) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        w_txd_lvl = 1'b1;
        if (w_bit_end) begin
          if (r_bitcnt == STOP_LAST) begin
            if (!w_empty) w_load = 1'b1;
            else          w_state_nxt = ST_IDLE;
          end else begin
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Pop the next byte; parity is fixed at pop time
    if (w_load) begin
      w_pop         = 1'b1;
      w_shreg_nxt   = w_fifo_data;
      w_par_nxt     = (^w_fifo_data) ^ ODD_PAR;
      w_bitcnt_nxt  = '0;
      w_baudcnt_nxt = BAUD_LOAD;
      w_state_nxt   = ST_START;
    end
  end

  assign txd      = r_txd;
  assign tx_ready = !w_full;
  assign busy     = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed + randomized bench for uart_byte_tx: two instances (DIV=10 even parity, DIV=434 odd parity 2 stops)
// whose txd lines are compared cycle by cycle against frames built from the byte stream.
module tb_uart_byte_tx;

  localparam int DIV_A = (1000 + 100 / 2) / 100;
  localparam int DIV_B = (50000000 + 115200 / 2) / 115200;

  logic       clk;
  logic       rst_n;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       ready_a, ready_b;
  logic       txd_a, txd_b;
  logic       busy_a, busy_b;
  logic [4:0] level_a, level_b;

  int n_vec;
  int n_err;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  uart_byte_tx #(
    .CLK_FREQ(1000), .BAUD(100), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n), .tx_data(data_a), .tx_valid(valid_a),
    .tx_ready(ready_a), .txd(txd_a), .busy(busy_a), .fifo_level(level_a)
  );

  uart_byte_tx #(
    .CLK_FREQ(50000000), .BAUD(115200), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n), .tx_data(data_b), .tx_valid(valid_b),
    .tx_ready(ready_b), .txd(txd_b), .busy(busy_b), .fifo_level(level_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_txd(input int which);
    return (which != 0) ? txd_b : txd_a;
  endfunction

  // Push one byte, waiting (bounded) for tx_ready; returns at the negedge after acceptance
  task automatic push(input int which, input logic [7:0] d);
    logic acc;
    bit   done;
    done = 1'b0;
    if (which == 0) begin data_a = d; valid_a = 1'b1; end
    else            begin data_b = d; valid_b = 1'b1; end
    for (int i = 0; i < 20000 && !done; i++) begin
      acc = (which == 0) ? ready_a : ready_b;
      @(negedge clk);
      if (acc) begin
        done = 1'b1;
        if (which == 0) exp_a.push_back(d); else exp_b.push_back(d);
      end
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    n_vec++;
    assert (done) else begin
      n_err++;
      $error("FAIL push_timeout: observed accepted=%0d expected accepted=1", done);
    end
  endtask

  // Frame from line rules: start 0, data LSB first, parity, stop bits at 1
  task automatic check_frame(input int which, input logic [7:0] d);
    logic bits[$];
    int   div;
    int   ones;
    div  = (which != 0) ? DIV_B : DIV_A;
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (which == 0) begin
      bits.push_back(1'((ones % 2) == 1));
      bits.push_back(1'b1);
    end else begin
      bits.push_back(1'((ones % 2) == 0));
      bits.push_back(1'b1);
      bits.push_back(1'b1);
    end
    for (int k = 0; k < bits.size(); k++) begin
      for (int c = 0; c < div; c++) begin
        chk($sformatf("txd%s byte=%02h bit=%0d cyc=%0d", (which != 0) ? "B" : "A", d, k, c),
            32'(get_txd(which)), 32'(bits[k]));
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_fall(input int which, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (get_txd(which) === 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    n_vec++;
    assert (ok) else begin
      n_err++;
      $error("FAIL start_timeout: observed start=0 expected start=1");
    end
  endtask

  // strict: after the first frame each start bit must follow the previous stop with no gap
  task automatic run_frames(input int which, input int n, input bit strict);
    bit ok;
    logic [7:0] d;
    bit have;
    for (int k = 0; k < n; k++) begin
      if (k == 0 || !strict) begin
        wait_fall(which, 20000, ok);
        if (!ok) return;
      end
      have = (which != 0) ? (exp_b.size() != 0) : (exp_a.size() != 0);
      n_vec++;
      assert (have) else begin
        n_err++;
        $error("FAIL frame_without_push: observed queued=0 expected queued=1");
      end
      if (!have) return;
      d = (which != 0) ? exp_b.pop_front() : exp_a.pop_front();
      check_frame(which, d);
    end
  endtask

  task automatic check_idle(input int which);
    chk("idle_txd",   32'((which != 0) ? txd_b : txd_a), 32'(1));
    chk("idle_busy",  32'((which != 0) ? busy_b : busy_a), 32'(0));
    chk("idle_level", 32'((which != 0) ? level_b : level_a), 32'(0));
    chk("idle_ready", 32'((which != 0) ? ready_b : ready_a), 32'(1));
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    data_a  = '0;
    data_b  = '0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (3) @(negedge clk);
    check_idle(0);
    check_idle(1);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: latency, bit order, idle afterwards
    push(0, 8'h55);
    chk("s1_level_after_push", 32'(level_a), 32'(1));
    chk("s1_busy_after_push", 32'(busy_a), 32'(1));
    @(negedge clk);
    chk("s1_txd_n+1", 32'(txd_a), 32'(1));
    chk("s1_level_after_pop", 32'(level_a), 32'(0));
    @(negedge clk);
    chk("s1_txd_n+2", 32'(txd_a), 32'(0));
    run_frames(0, 1, 1'b0);
    check_idle(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("s1_idle_hold", 32'(txd_a), 32'(1));
    end

    // Even parity on 0x07 gives a 1 parity bit; 110-cycle frame
    push(0, 8'h07);
    run_frames(0, 1, 1'b0);
    check_idle(0);

    // Back-pressure with valid held high over 0x00..0x1F
    fork
      begin
        int   idx;
        logic prev;
        bit   seen;
        idx = 0;
        seen = 1'b0;
        data_a = 8'h00;
        valid_a = 1'b1;
        prev = ready_a;
        for (int cyc = 0; cyc < 6000 && idx < 32; cyc++) begin
          @(negedge clk);
          if (prev) begin
            exp_a.push_back(data_a);
            idx++;
          end
          if (!ready_a && !seen) begin
            seen = 1'b1;
            chk("s3_accepted_at_full", 32'(idx), 32'(17));
            chk("s3_level_at_full", 32'(level_a), 32'(16));
          end
          if (idx == 32) valid_a = 1'b0;
          else           data_a = 8'(idx);
          prev = ready_a;
        end
        valid_a = 1'b0;
        chk("s3_ready_dropped", 32'(seen), 32'(1));
        chk("s3_all_accepted", 32'(idx), 32'(32));
      end
      run_frames(0, 32, 1'b1);
    join
    check_idle(0);

    // Push coinciding with the pop at the end of a stop bit
    push(0, 8'hA1);
    chk("s4_level_a1", 32'(level_a), 32'(1));
    push(0, 8'hB2);
    chk("s4_level_b2", 32'(level_a), 32'(1));
    fork
      begin
        repeat (109) @(negedge clk);
        chk("s4_level_before", 32'(level_a), 32'(1));
        push(0, 8'hC3);
        chk("s4_level_after", 32'(level_a), 32'(1));
      end
      run_frames(0, 3, 1'b1);
    join
    check_idle(0);

    // Mid-frame reset during bit 3 of 0xA5 with another byte queued
    push(0, 8'hA5);
    push(0, 8'h11);
    begin
      bit ok;
      wait_fall(0, 100, ok);
    end
    repeat (44) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle(0);
    exp_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("s5_no_residual_txd", 32'(txd_a), 32'(1));
      chk("s5_no_residual_busy", 32'(busy_a), 32'(0));
    end
    push(0, 8'h3C);
    run_frames(0, 1, 1'b0);
    check_idle(0);

    // Default rate (434 cycles/bit), odd parity, two stop bits, back-to-back
    push(1, 8'hC3);
    push(1, 8'h07);
    run_frames(1, 2, 1'b1);
    check_idle(1);

    // Random bytes with random producer gaps
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          repeat ($urandom_range(0, 150)) @(negedge clk);
          push(0, 8'($urandom));
        end
      end
      run_frames(0, 10, 1'b0);
    join
    repeat (2) @(negedge clk);
    check_idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
